// File: rtl/router_pkg.sv
// Shared router datapath definitions: FSM state encodings, default header geometry
// and the XOR helper used to accumulate packet parity.
package router_pkg;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_PARITY        = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        WAIT_TILL_EMPTY    = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } router_state_e;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_ADDR_W    = 2;
    localparam int DEF_NUM_PORTS = 3;
    localparam int ADDR_LSB      = 0;
    localparam int MAX_W         = 32;

    // Byte-wise XOR fold; callers zero-extend to MAX_W and truncate the result.
    function automatic logic [MAX_W-1:0] parity_f(input logic [MAX_W-1:0] acc,
                                                  input logic [MAX_W-1:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity over header and payload, capture of the trailing parity byte,
// and the per-packet sticky parity error.
module router_parity_chk
    import router_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic              clock,
    input  logic              resetn,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] hdr,
    input  logic              hdr_cap,
    input  logic              lfd_go,
    input  logic              ld_pay,
    input  logic              ld_par,
    input  logic              parity_set,
    output logic              parity_done,
    output logic              err
);

    logic [DATA_W-1:0] int_par_q, int_par_d;
    logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
    logic              parity_done_q, parity_done_d;
    logic              pd_prev_q;
    logic              err_q, err_d;

    always_comb begin
        int_par_d     = int_par_q;
        pkt_par_d     = pkt_par_q;
        parity_done_d = parity_done_q;
        err_d         = err_q;
        if (hdr_cap) begin
            int_par_d = '0;
        end else if (lfd_go) begin
            int_par_d = hdr;
        end else if (ld_pay) begin
            int_par_d = DATA_W'(parity_f(MAX_W'(int_par_q), MAX_W'(data_in)));
        end
        if (ld_par) pkt_par_d = data_in;
        if (parity_set) parity_done_d = 1'b1;
        // Compare one cycle after parity_done rises, once both bytes are settled.
        if (parity_done_q && !pd_prev_q) err_d = err_q | (int_par_q != pkt_par_q);
        if (hdr_cap) begin
            parity_done_d = 1'b0;
            err_d         = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            int_par_q     <= '0;
            pkt_par_q     <= '0;
            parity_done_q <= 1'b0;
            pd_prev_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            int_par_q     <= int_par_d;
            pkt_par_q     <= pkt_par_d;
            parity_done_q <= parity_done_d;
            pd_prev_q     <= parity_done_q;
            err_q         <= err_d;
        end
    end

    assign parity_done = parity_done_q;
    assign err         = err_q;

endmodule

// File: rtl/router_pkt_reg.sv
// Router datapath register stage: header/hold/dout muxing, address check and payload counting.
// Optional payload-length check is built when ROUTER_REG_LEN_CHECK_EN is defined.
module router_pkt_reg
    import router_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_PORTS = DEF_NUM_PORTS
)(
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              laf_state,
    input  logic              full_state,
    input  logic              rst_int_reg,
    output logic [DATA_W-1:0] dout,
    output logic              err,
    output logic              addr_err,
    output logic              len_err,
    output logic              parity_done,
    output logic              low_pkt_valid
);

    localparam int LEN_W = DATA_W - ADDR_W;

    logic              hdr_cap, lfd_go, ld_go, laf_go, ld_pay, ld_par, parity_set;
    logic [DATA_W-1:0] hdr_q, hdr_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              hold_pay_q, hold_pay_d;
    logic              addr_err_q, addr_err_d;
    logic              low_pkt_valid_q, low_pkt_valid_d;
    logic [LEN_W-1:0]  pay_cnt_q, pay_cnt_d;
    logic              pay_inc;

    assign hdr_cap    = detect_add & pkt_valid;
    assign lfd_go     = ~detect_add & lfd_state;
    assign ld_go      = ~detect_add & ~lfd_state & ld_state & ~full_state;
    assign laf_go     = ~detect_add & ~lfd_state & ~ld_state & laf_state;
    assign ld_pay     = ld_go & pkt_valid;
    assign ld_par     = ld_go & ~pkt_valid;
    // A parity byte parked in hold is only complete once laf_state writes it out.
    assign parity_set = (ld_par & ~fifo_full) | (laf_go & low_pkt_valid_q & ~parity_done);

    always_comb begin
        hdr_d           = hdr_q;
        hold_d          = hold_q;
        hold_pay_d      = hold_pay_q;
        dout_d          = dout_q;
        addr_err_d      = addr_err_q;
        pay_cnt_d       = pay_cnt_q;
        low_pkt_valid_d = low_pkt_valid_q;
        pay_inc         = 1'b0;
        if (hdr_cap) begin
            hdr_d      = data_in;
            addr_err_d = ({{(32-ADDR_W){1'b0}}, data_in[ADDR_LSB +: ADDR_W]} >= 32'(NUM_PORTS));
        end else if (lfd_go) begin
            dout_d    = hdr_q;
            pay_cnt_d = '0;
        end else if (ld_go) begin
            if (fifo_full) begin
                hold_d     = data_in;
                hold_pay_d = pkt_valid;
            end else begin
                dout_d  = data_in;
                pay_inc = pkt_valid;
            end
        end else if (laf_go) begin
            dout_d  = hold_q;
            pay_inc = hold_pay_q;
        end
        if (pay_inc && (pay_cnt_q != {LEN_W{1'b1}})) pay_cnt_d = pay_cnt_q + LEN_W'(1);
        if (rst_int_reg) low_pkt_valid_d = 1'b0;
        if (ld_par) low_pkt_valid_d = 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hdr_q           <= '0;
            hold_q          <= '0;
            hold_pay_q      <= 1'b0;
            dout_q          <= '0;
            addr_err_q      <= 1'b0;
            pay_cnt_q       <= '0;
            low_pkt_valid_q <= 1'b0;
        end else begin
            hdr_q           <= hdr_d;
            hold_q          <= hold_d;
            hold_pay_q      <= hold_pay_d;
            dout_q          <= dout_d;
            addr_err_q      <= addr_err_d;
            pay_cnt_q       <= pay_cnt_d;
            low_pkt_valid_q <= low_pkt_valid_d;
        end
    end

    router_parity_chk #(.DATA_W(DATA_W)) u_parity_chk (
        .clock       (clock),
        .resetn      (resetn),
        .data_in     (data_in),
        .hdr         (hdr_q),
        .hdr_cap     (hdr_cap),
        .lfd_go      (lfd_go),
        .ld_pay      (ld_pay),
        .ld_par      (ld_par),
        .parity_set  (parity_set),
        .parity_done (parity_done),
        .err         (err)
    );

`ifdef ROUTER_REG_LEN_CHECK_EN
    logic len_err_q, len_err_d;

    always_comb begin
        len_err_d = len_err_q;
        if (parity_set && !parity_done) len_err_d = len_err_q | (pay_cnt_q != hdr_q[DATA_W-1:ADDR_W]);
        if (hdr_cap) len_err_d = 1'b0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) len_err_q <= 1'b0;
        else         len_err_q <= len_err_d;
    end

    assign len_err = len_err_q;
`else
    assign len_err = 1'b0;
`endif

    assign dout          = dout_q;
    assign addr_err      = addr_err_q;
    assign low_pkt_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_router_pkt_reg.sv
// Directed bench for router_pkt_reg: table-driven packet flows on an 8-bit instance,
// plus hand-written reset, saturation and 16-bit sequences.
`timescale 1ns/1ps
module tb_router_pkt_reg;

`ifdef ROUTER_REG_LEN_CHECK_EN
    localparam int LE = 1;
`else
    localparam int LE = 0;
`endif

    localparam int ST_IDLE = 0, ST_DA = 1, ST_LFD = 2, ST_LD = 3, ST_FULL = 4, ST_LAF = 5;

    logic        clock, resetn;
    logic        pkt_valid, fifo_full, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic [7:0]  data_in, dout;
    logic        err, addr_err, len_err, parity_done, low_pkt_valid;
    logic [15:0] data_in16, dout16;
    logic        err16, addr_err16, len_err16, pd16, lpv16;

    int checks = 0;
    int errors = 0;

    router_pkt_reg u_dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout), .err(err), .addr_err(addr_err),
        .len_err(len_err), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid)
    );

    router_pkt_reg #(.DATA_W(16), .ADDR_W(3), .NUM_PORTS(5)) u_dut16 (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in16),
        .fifo_full(fifo_full), .detect_add(detect_add), .lfd_state(lfd_state),
        .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
        .rst_int_reg(rst_int_reg), .dout(dout16), .err(err16), .addr_err(addr_err16),
        .len_err(len_err16), .parity_done(pd16), .low_pkt_valid(lpv16)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int         st;
        logic       pv, ff, ri;
        logic [7:0] din;
        logic [7:0] e_dout;
        logic       e_err, e_aerr, e_pd, e_lpv, e_lerr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int st, int pv, int ff, int ri, int din,
                                int ed, int ee, int ea, int ep, int el, int elen);
        vec_t v;
        v.st = st; v.pv = pv[0]; v.ff = ff[0]; v.ri = ri[0]; v.din = din[7:0];
        v.e_dout = ed[7:0]; v.e_err = ee[0]; v.e_aerr = ea[0]; v.e_pd = ep[0];
        v.e_lpv = el[0]; v.e_lerr = elen[0];
        return v;
    endfunction

    task automatic drive(input int st, input int pv, input int ff, input int ri,
                         input int d8, input int d16);
        detect_add  = (st == ST_DA);
        lfd_state   = (st == ST_LFD);
        ld_state    = (st == ST_LD);
        full_state  = (st == ST_FULL);
        laf_state   = (st == ST_LAF);
        pkt_valid   = (pv != 0);
        fifo_full   = (ff != 0);
        rst_int_reg = (ri != 0);
        data_in     = d8[7:0];
        data_in16   = d16[15:0];
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_rows(input int first, input int last, input string tag);
        for (int i = first; i <= last; i++) begin
            drive(tbl[i].st, int'(tbl[i].pv), int'(tbl[i].ff), int'(tbl[i].ri), int'(tbl[i].din), 0);
            step();
            chk($sformatf("%s[%0d] dout", tag, i), 32'(dout), 32'(tbl[i].e_dout));
            chk($sformatf("%s[%0d] err", tag, i), 32'(err), 32'(tbl[i].e_err));
            chk($sformatf("%s[%0d] addr_err", tag, i), 32'(addr_err), 32'(tbl[i].e_aerr));
            chk($sformatf("%s[%0d] parity_done", tag, i), 32'(parity_done), 32'(tbl[i].e_pd));
            chk($sformatf("%s[%0d] low_pkt_valid", tag, i), 32'(low_pkt_valid), 32'(tbl[i].e_lpv));
            chk($sformatf("%s[%0d] len_err", tag, i), 32'(len_err), 32'(tbl[i].e_lerr));
        end
    endtask

    initial begin
        int a_s, a_e, b_s, b_e, c_s, c_e, d_s, d_e, e_s, e_e;
        logic [15:0] p16 [5];
        p16[0] = 16'h1111; p16[1] = 16'h2222; p16[2] = 16'h3333; p16[3] = 16'h4444; p16[4] = 16'h5555;

        resetn = 1'b0;
        drive(ST_IDLE, 0, 0, 0, 0, 0);

        // Test 1: header 0x16 (len 5, addr 2), correct parity 0x07
        a_s = tbl.size();
        tbl.push_back(mk(ST_DA,   1,0,0,'h16, 'h00,0,0,0,0,0));
        tbl.push_back(mk(ST_LFD,  1,0,0,'h11, 'h16,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h11, 'h11,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h22, 'h22,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h33, 'h33,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h44, 'h44,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h55, 'h55,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   0,0,0,'h07, 'h07,0,0,1,1,0));
        tbl.push_back(mk(ST_IDLE, 0,0,1,'h00, 'h07,0,0,1,0,0));
        tbl.push_back(mk(ST_IDLE, 0,0,0,'h00, 'h07,0,0,1,0,0));
        a_e = tbl.size() - 1;
        // Test 2: bad parity 0x06; rst_int_reg coincident with parity load (set wins)
        b_s = tbl.size();
        tbl.push_back(mk(ST_DA,   1,0,0,'h16, 'h07,0,0,0,0,0));
        tbl.push_back(mk(ST_LFD,  1,0,0,'h11, 'h16,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h11, 'h11,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h22, 'h22,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h33, 'h33,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h44, 'h44,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h55, 'h55,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   0,0,1,'h06, 'h06,0,0,1,1,0));
        tbl.push_back(mk(ST_IDLE, 0,0,1,'h00, 'h06,1,0,1,0,0));
        tbl.push_back(mk(ST_IDLE, 0,0,0,'h00, 'h06,1,0,1,0,0));
        b_e = tbl.size() - 1;
        // Test 3: addr 3 is out of range; next detect_add clears err and addr_err
        c_s = tbl.size();
        tbl.push_back(mk(ST_DA,   1,0,0,'h17, 'h06,0,1,0,0,0));
        tbl.push_back(mk(ST_IDLE, 0,0,0,'h00, 'h06,0,1,0,0,0));
        tbl.push_back(mk(ST_DA,   1,0,0,'h15, 'h06,0,0,0,0,0));
        c_e = tbl.size() - 1;
        // Test 4: FIFO full on payload 2, drained through laf_state; parity 0x04
        d_s = tbl.size();
        tbl.push_back(mk(ST_LFD,  1,0,0,'h11, 'h15,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h11, 'h11,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h22, 'h22,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,1,0,'h33, 'h22,0,0,0,0,0));
        tbl.push_back(mk(ST_FULL, 1,1,0,'h33, 'h22,0,0,0,0,0));
        tbl.push_back(mk(ST_FULL, 1,1,0,'h33, 'h22,0,0,0,0,0));
        tbl.push_back(mk(ST_FULL, 1,0,0,'h33, 'h22,0,0,0,0,0));
        tbl.push_back(mk(ST_LAF,  1,0,0,'h44, 'h33,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h44, 'h44,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h55, 'h55,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   0,0,0,'h04, 'h04,0,0,1,1,0));
        tbl.push_back(mk(ST_IDLE, 0,0,1,'h00, 'h04,0,0,1,0,0));
        tbl.push_back(mk(ST_IDLE, 0,0,0,'h00, 'h04,0,0,1,0,0));
        d_e = tbl.size() - 1;
        // Test 5: len 5 but 4 payloads; parity byte hits a full FIFO, done in laf_state
        e_s = tbl.size();
        tbl.push_back(mk(ST_DA,   1,0,0,'h16, 'h04,0,0,0,0,0));
        tbl.push_back(mk(ST_LFD,  1,0,0,'h11, 'h16,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h11, 'h11,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h22, 'h22,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h33, 'h33,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   1,0,0,'h44, 'h44,0,0,0,0,0));
        tbl.push_back(mk(ST_LD,   0,1,0,'h52, 'h44,0,0,0,1,0));
        tbl.push_back(mk(ST_FULL, 0,0,0,'h52, 'h44,0,0,0,1,0));
        tbl.push_back(mk(ST_LAF,  0,0,0,'h52, 'h52,0,0,1,1,LE));
        tbl.push_back(mk(ST_IDLE, 0,0,1,'h00, 'h52,0,0,1,0,LE));
        tbl.push_back(mk(ST_IDLE, 0,0,0,'h00, 'h52,0,0,1,0,LE));
        e_e = tbl.size() - 1;

        repeat (2) @(negedge clock);
        chk("reset dout", 32'(dout), 32'h0);
        chk("reset err", 32'(err), 32'h0);
        chk("reset addr_err", 32'(addr_err), 32'h0);
        chk("reset len_err", 32'(len_err), 32'h0);
        chk("reset parity_done", 32'(parity_done), 32'h0);
        chk("reset low_pkt_valid", 32'(low_pkt_valid), 32'h0);
        resetn = 1'b1;

        run_rows(a_s, a_e, "t1");
        run_rows(b_s, b_e, "t2");
        run_rows(c_s, c_e, "t3");
        run_rows(d_s, d_e, "t4");
        run_rows(e_s, e_e, "t5");

        // Test 6: asynchronous reset in the middle of a packet
        drive(ST_DA, 1, 0, 0, 'h17, 0);  step();
        drive(ST_LFD, 1, 0, 0, 'h11, 0); step();
        drive(ST_LD, 1, 0, 0, 'h11, 0);  step();
        chk("t6 pre dout", 32'(dout), 32'h11);
        chk("t6 pre addr_err", 32'(addr_err), 32'h1);
        drive(ST_LD, 1, 0, 0, 'h22, 0);
        #2 resetn = 1'b0;
        #1;
        chk("t6 async dout", 32'(dout), 32'h0);
        chk("t6 async err", 32'(err), 32'h0);
        chk("t6 async addr_err", 32'(addr_err), 32'h0);
        chk("t6 async len_err", 32'(len_err), 32'h0);
        chk("t6 async parity_done", 32'(parity_done), 32'h0);
        chk("t6 async low_pkt_valid", 32'(low_pkt_valid), 32'h0);
        @(negedge clock);
        drive(ST_IDLE, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        run_rows(a_s, a_e, "t6clean");

        // Payload counter saturation: len 63, 70 payloads
        drive(ST_DA, 1, 0, 0, 'hFC, 0); step();
        chk("sat addr_err", 32'(addr_err), 32'h0);
        drive(ST_LFD, 1, 0, 0, 0, 0); step();
        chk("sat hdr dout", 32'(dout), 32'hFC);
        for (int i = 0; i < 70; i++) begin
            drive(ST_LD, 1, 0, 0, 0, 0);
            step();
        end
        drive(ST_LD, 0, 0, 0, 'hFC, 0); step();
        chk("sat dout", 32'(dout), 32'hFC);
        chk("sat parity_done", 32'(parity_done), 32'h1);
        chk("sat len_err", 32'(len_err), 32'h0);
        drive(ST_IDLE, 0, 0, 1, 0, 0); step();
        chk("sat err", 32'(err), 32'h0);

        // Test 7: 16-bit instance, header len 5 addr 2, parity 0x113B
        drive(ST_DA, 1, 0, 0, 0, 'h002A); step();
        chk("t7 addr_err", 32'(addr_err16), 32'h0);
        chk("t7 pd clear", 32'(pd16), 32'h0);
        drive(ST_LFD, 1, 0, 0, 0, 'h1111); step();
        chk("t7 hdr dout", 32'(dout16), 32'h002A);
        for (int i = 0; i < 5; i++) begin
            drive(ST_LD, 1, 0, 0, 0, int'(p16[i]));
            step();
            chk($sformatf("t7 p%0d dout", i), 32'(dout16), 32'(p16[i]));
        end
        drive(ST_LD, 0, 0, 0, 0, 'h113B); step();
        chk("t7 par dout", 32'(dout16), 32'h113B);
        chk("t7 parity_done", 32'(pd16), 32'h1);
        chk("t7 low_pkt_valid", 32'(lpv16), 32'h1);
        drive(ST_IDLE, 0, 0, 1, 0, 0); step();
        chk("t7 err", 32'(err16), 32'h0);
        chk("t7 lpv clear", 32'(lpv16), 32'h0);
        chk("t7 len_err", 32'(len_err16), 32'h0);
        drive(ST_DA, 1, 0, 0, 0, 'h002D); step();
        chk("t7 addr5 addr_err", 32'(addr_err16), 32'h1);
        drive(ST_DA, 1, 0, 0, 0, 'h002C); step();
        chk("t7 addr4 addr_err", 32'(addr_err16), 32'h0);
        drive(ST_IDLE, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
